adam_aes_sbox_array: RTL and testbench
======================================

Name: adam_aes_sbox_array

Overview:
Parametrised, pipelined multi-lane AES S-box engine. It succeeds the single-byte combinational S-box. It substitutes NUM_LANES bytes per beat, in forward (SubBytes) or inverse (InvSubBytes) mode selected per beat, and supports a per-lane bypass mask. It sits between the AES round datapath / key expansion and the state registers, with valid/ready flow control on both sides.

Parameters:
NUM_LANES, 4, number of bytes substituted per beat (1..16); data width = 8*NUM_LANES
OUT_REG, 1, 0 = single pipeline stage (latency 1); 1 = extra output register stage (latency 2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  engine can accept a beat this cycle
in_data  in  8*NUM_LANES  input bytes, lane i = in_data[8i+7:8i]
in_inv  in  1  0 = forward S-box, 1 = inverse S-box, sampled with beat
in_mask  in  NUM_LANES  1 = substitute lane, 0 = pass lane byte through unchanged
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output beat
out_data  out  8*NUM_LANES  substituted bytes, lane order preserved
out_inv  out  1  in_inv of the beat currently on out_data

Behaviour:
- Reset: synchronous, active-high. Applies to all stage valid flags, out_valid, out_data (0) and out_inv (0), and clears all in-flight beats with no partial output. in_ready = 0 while rst is high; it becomes combinationally valid from the first cycle after rst deasserts.
- Handshake: a beat transfers in when in_valid && in_ready, and out when out_valid && out_ready.
  - in_data, in_inv and in_mask are sampled only on an accepted beat.
  - out_data and out_inv stay stable while out_valid && !out_ready.
- Stage 1 (always present):
  - On an input transfer, register per lane: mask ? (inv ? INV_SBOX(byte) : SBOX(byte)) : byte.
  - Also register inv and the valid flag.
  - The S-box lookup is combinational before the stage-1 register.
  - Forward table is FIPS-197 SubBytes; inverse table is FIPS-197 InvSubBytes.
- Stage 2 (OUT_REG=1): a plain register of stage-1 data, inv and valid. It advances when empty or when out_ready is high.
- Flow control: each stage loads when it is empty or its downstream consumer takes its content in the same cycle.
  - in_ready = !s1_valid || s1_advance.
  - Full throughput of 1 beat/cycle when out_ready stays high.
  - No bubbles are inserted.
  - Simultaneous accept and emit on a full pipe is legal and loses no data.
- Latency (in_valid && in_ready at cycle N, out_ready high):
  - OUT_REG=0: out_valid in cycle N+1.
  - OUT_REG=1: out_valid in cycle N+2.
- Backpressure:
  - With out_ready low, the pipe fills (1 or 2 beats), then in_ready drops the same cycle the last stage holds and stage 1 is full.
  - in_ready may depend combinationally on out_ready.
  - out_valid never depends combinationally on in_valid.
- Ordering: strict FIFO order; per-beat inv and mask are honoured independently, so forward and inverse beats may interleave back-to-back.
- Width rules: lanes are independent; no carry or interaction between bytes. NUM_LANES outside 1..16 is an elaboration error.
- X handling: in_data/in_inv/in_mask are ignored when in_valid is low. Stage registers hold their value when not loading.

Test Plan:
- Reset then single beat, NUM_LANES=4, OUT_REG=1, in_data=32'h5301_0000, inv=0, mask=4'hF -> out_data=32'hED7C_6363 at cycle N+2; out_valid one cycle with out_ready=1.
- Inverse beat in_data=32'hED7C_6363, inv=1, mask=4'hF -> out_data=32'h5301_0000, out_inv=1.
- Mask test in_data=32'h0000_0000, inv=0, mask=4'b0101 -> out_data=32'h0063_0063.
- Streaming 16 back-to-back beats, alternating inv, out_ready=1 -> 16 consecutive out_valid cycles, correct per-beat mode, in_ready never low.
- Backpressure: out_ready=0 for 5 cycles while feeding -> in_ready low after 2 accepted beats (OUT_REG=1) or 1 beat (OUT_REG=0); out_data stable. Release -> beats drain in order, none lost or duplicated.
- Reset mid-stream with 2 beats in flight -> out_valid=0 and out_data=0 the cycle after rst; no stale beat emitted afterwards. Exhaustive 256-value forward/inverse round-trip per lane returns the input.

Source files
------------

// File: rtl/adam_aes_sbox_array.sv
// adam_aes_sbox_array: pipelined multi-lane AES S-box (forward/inverse per beat, per-lane bypass)
// with valid/ready flow control and an optional output register stage.
module adam_aes_sbox_array #(
   parameter int NUM_LANES = 4,
   parameter int OUT_REG   = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [8*NUM_LANES-1:0] in_data,
   input  logic                   in_inv,
   input  logic [NUM_LANES-1:0]   in_mask,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*NUM_LANES-1:0] out_data,
   output logic                   out_inv
);
   localparam int W = 8*NUM_LANES;
   localparam logic [0:255][7:0] sbox_fwd = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };
   localparam logic [0:255][7:0] sbox_inv = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };
   if (NUM_LANES < 1 || NUM_LANES > 16) begin : g_bad_lanes
      $error("NUM_LANES must be in 1..16");
   end
   logic [W-1:0] sub, s1_data, s2_data;
   logic         s1_valid, s1_inv, s2_valid, s2_inv, s1_take, in_fire;
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign sub[8*i+:8] = !in_mask[i] ? in_data[8*i+:8] :
                           in_inv      ? sbox_inv[in_data[8*i+:8]] : sbox_fwd[in_data[8*i+:8]];
   end
   // Stage 1 empties when whatever follows it (stage 2 or the consumer) takes it this cycle.
   assign s1_take  = (OUT_REG != 0) ? (!s2_valid || out_ready) : out_ready;
   assign in_ready = !rst && (!s1_valid || s1_take);
   assign in_fire  = in_valid && in_ready;
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_inv   <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= in_fire || (s1_valid && !s1_take);
         if (in_fire) begin
            s1_data <= sub;
            s1_inv  <= in_inv;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_inv   <= 1'b0;
         s2_data  <= '0;
      end else if (!s2_valid || out_ready) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data <= s1_data;
            s2_inv  <= s1_inv;
         end
      end
   end
   assign out_valid = (OUT_REG != 0) ? s2_valid : s1_valid;
   assign out_data  = (OUT_REG != 0) ? s2_data  : s1_data;
   assign out_inv   = (OUT_REG != 0) ? s2_inv   : s1_inv;
endmodule

// File: tb/tb_adam_aes_sbox_array.sv
// tb_adam_aes_sbox_array: scoreboard bench for the 4-lane, two-stage S-box engine.
module tb_adam_aes_sbox_array;
   typedef struct {
      logic [31:0] d;
      logic        inv;
      bit          cap;
      int          idx;
      int          cyc;
   } exp_t;
   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1;
   logic [31:0] in_data = '0;
   logic [3:0]  in_mask = '0;
   logic        in_ready, out_valid, out_inv;
   logic [31:0] out_data;
   exp_t        q[$];
   logic [31:0] cap_arr [256];
   int          cyc = 0, n_cmp = 0, n_err = 0, stalls = 0;

   adam_aes_sbox_array #(.NUM_LANES(4), .OUT_REG(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_inv(in_inv), .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_inv(out_inv)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] d, input logic inv, input logic [3:0] m,
                       input logic [31:0] e, input bit cap, input int idx, input bit lat);
      exp_t x;
      bit   done = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_inv = inv; in_mask = m;
      for (int t = 0; t < 50 && !done; t++) begin
         if (t > 0) @(negedge clk);
         #1;
         if (in_ready) begin
            x.d = e; x.inv = inv; x.cap = cap; x.idx = idx; x.cyc = lat ? cyc : -1;
            q.push_back(x);
            done = 1;
         end else stalls++;
         @(posedge clk);
      end
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout: beat %h never accepted", d);
      end
   endtask

   task automatic drain();
      @(negedge clk);
      in_valid = 1'b0;
      for (int t = 0; t < 2000 && q.size() != 0; t++) @(negedge clk);
      if (q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL drain_timeout: %0d beats still pending, expected 0", q.size());
      end
   endtask

   // Monitor: pops the scoreboard whenever a beat leaves the engine.
   always @(negedge clk) begin
      exp_t x;
      #2;
      if (!rst && out_valid && out_ready) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_out: got %h with empty scoreboard, expected no beat", out_data);
         end else begin
            x = q.pop_front();
            if (x.cap) begin
               cap_arr[x.idx] = out_data;
               if (out_inv !== x.inv) begin
                  n_err++;
                  $display("FAIL cap_inv[%0d]: got %b expected %b", x.idx, out_inv, x.inv);
               end
            end else if (out_data !== x.d || out_inv !== x.inv) begin
               n_err++;
               $display("FAIL out_beat: got %h/%b expected %h/%b", out_data, out_inv, x.d, x.inv);
            end
            if (x.cyc >= 0) begin
               n_cmp++;
               if (cyc != x.cyc + 2) begin
                  n_err++;
                  $display("FAIL latency: got cycle %0d expected %0d", cyc, x.cyc + 2);
               end
            end
         end
      end
   end

   initial begin
      int          acc;
      logic [31:0] d;
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      send(32'h5301_0000, 1'b0, 4'hF, 32'hED7C_6363, 0, 0, 1);
      drain();
      send(32'hED7C_6363, 1'b1, 4'hF, 32'h5301_0000, 0, 0, 1);
      drain();
      send(32'h0000_0000, 1'b0, 4'b0101, 32'h0063_0063, 0, 0, 1);
      send(32'hFFFF_FFFF, 1'b0, 4'hF, 32'h1616_1616, 0, 0, 1);
      send(32'h0000_0000, 1'b1, 4'hF, 32'h5252_5252, 0, 0, 1);
      send(32'h1234_5678, 1'b1, 4'h0, 32'h1234_5678, 0, 0, 1);
      drain();

      stalls = 0;
      for (int k = 0; k < 16; k++)
         if (k % 2 == 0) send(32'h5301_0010, 1'b0, 4'hF, 32'hED7C_63CA, 0, 0, 1);
         else            send(32'hED7C_63CA, 1'b1, 4'hF, 32'h5301_0010, 0, 0, 1);
      check("stream_stalls", stalls, 32'd0);
      drain();

      acc = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_00A0 + acc; in_inv = acc[0]; in_mask = 4'h0;
         #1;
         if (in_ready) begin
            q.push_back('{d: in_data, inv: in_inv, cap: 0, idx: 0, cyc: -1});
            acc++;
         end
         @(posedge clk);
      end
      @(negedge clk);
      #1;
      check("bp_accepted", acc, 32'd2);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data_held", out_data, 32'h0000_00A0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      out_ready = 1'b0;
      send(32'h5301_0000, 1'b1, 4'hF, 32'h0, 0, 0, 0);
      send(32'hED7C_6363, 1'b1, 4'hF, 32'h0, 0, 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
      check("pre_rst_out_inv", {31'd0, out_inv}, 32'd1);
      rst = 1'b1;
      q.delete();
      #1;
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_out_data", out_data, 32'd0);
      check("mid_rst_out_inv", {31'd0, out_inv}, 32'd0);
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      send(32'h0000_0001, 1'b0, 4'hF, 32'h6363_637C, 0, 0, 1);
      drain();

      for (int k = 0; k < 256; k++) begin
         d = {8'(k + 3), 8'(k + 2), 8'(k + 1), 8'(k)};
         send(d, 1'b0, 4'hF, 32'h0, 1, k, 1);
      end
      drain();
      for (int k = 0; k < 256; k++) begin
         d = {8'(k + 3), 8'(k + 2), 8'(k + 1), 8'(k)};
         send(cap_arr[k], 1'b1, 4'hF, d, 0, 0, 1);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
